instr_packer: RTL
=================

INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'd0, meaning the first value of out_addr after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, request accepted this cycle when high together with in_valid.
REQ-006 SHALL have ports in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, inputs, widths 7/5/5/5/3/7, the instruction fields.
REQ-007 SHALL have port in_imm, input, 64, a sign-extended immediate in the processor's immediate-generator convention.
REQ-008 SHALL have port out_valid, output, 1, output entry present.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the entry when high together with out_valid.
REQ-010 SHALL have ports out_instr (32), out_addr (64) and out_err (1), outputs, giving the packed word, its word address and an error flag.

Function
REQ-011 SHALL pack the fields on acceptance and push the word, address and error flag into a 2-entry FIFO; first out_valid occurs 1 cycle after acceptance.
REQ-012 SHALL pack opcodes 0000011 and 0010011 as I-type: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
REQ-013 SHALL pack 0100011 as S-type: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
REQ-014 SHALL pack 0110011 as R-type: [31:25]=funct7, [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
REQ-015 SHALL pack 1100011 as SB-type with imm as a 12-bit halfword offset: [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0], plus rs2, rs1 and funct3 as for S-type.
REQ-016 SHALL place in_opcode in [6:0] for every supported opcode.
REQ-017 SHALL drive out_instr=0 and out_err=1 for any other opcode.
REQ-018 SHALL tag each entry with the current address counter value.
REQ-019 SHALL advance the address counter by 4 only on acceptance of a non-error entry; wrap-around is modulo 2^64.
REQ-020 SHALL drive in_ready = FIFO not full; in_ready SHALL have no combinational dependence on out_ready.
REQ-021 SHALL, on a simultaneous push and pop, keep occupancy unchanged and preserve FIFO order.
REQ-022 SHALL hold out_instr, out_addr and out_err stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when the FIFO is empty, drive out_valid=0 and hold the data outputs at their last value.

Reset
REQ-024 SHALL, while reset=1, empty the FIFO, load the address counter with BASE_ADDR, and drive out_valid=0, in_ready=0, out_instr=0, out_err=0 and out_addr=BASE_ADDR.
REQ-025 SHALL discard any in-flight or buffered entry on reset mid-operation.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, with INSTR_PACKER_RANGE_CHECK_EN defined, set out_err=1 and out_instr=0 whenever in_imm[63:11] is not all equal to in_imm[11] for I/S/SB opcodes.
REQ-028 SHALL, without INSTR_PACKER_RANGE_CHECK_EN, silently truncate the immediate and flag errors only for unsupported opcodes.

Structure
REQ-029 SHALL take the following from a shared package, cpu_pkg: opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_REG), field widths, and an enum for instruction format.
REQ-030 SHALL instantiate one sub-module, instr_fifo2, a 2-entry 97-bit synchronous FIFO with full/empty flags.

Verification
REQ-031 SHALL cover: I-type ld (opcode 0000011, rd=5, rs1=2, funct3=011, imm=-8) -> out_instr 32'hFF813283, out_addr 0, out_err 0.
REQ-032 SHALL cover: S-type sd (opcode 0100011, rs1=2, rs2=6, funct3=011, imm=16) -> out_instr 32'h00613823.
REQ-033 SHALL cover: SB-type beq (opcode 1100011, rs1=1, rs2=2, funct3=000, imm=-2) -> out_instr 32'hFE208EE3; decoding it back through the processor's immediate generator returns -2.
REQ-034 SHALL cover: with the macro defined, addi with imm=2048 -> out_err 1, out_instr 0, and the next accepted entry still gets the unadvanced address.
REQ-035 SHALL cover: out_ready=0 with 3 valid requests -> in_ready falls after 2 acceptances; after out_ready rises, entries emerge in order with addresses 0, 4, 8.
REQ-036 SHALL cover: reset asserted with 2 entries buffered -> out_valid 0 next cycle; the first post-reset entry gets out_addr=BASE_ADDR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, field widths, instruction formats and the packer
// FIFO entry layout.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned ILEN     = 32;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {FmtI, FmtS, FmtSb, FmtR, FmtBad} fmt_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            err;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  function automatic fmt_e decode_fmt(input logic [OPCODE_W-1:0] op);
    fmt_e fmt;
    case (op)
      OP_LOAD, OP_IMM: fmt = FmtI;
      OP_STORE:        fmt = FmtS;
      OP_BRANCH:       fmt = FmtSb;
      OP_REG:          fmt = FmtR;
      default:         fmt = FmtBad;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry synchronous FIFO with full/empty flags. Caller must not push when full nor pop
// when empty.
module instr_fifo2 #(
  parameter int unsigned Width = 97
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push && !pop)      count_q <= count_q + 2'd1;
      else if (pop && !push) count_q <= count_q - 2'd1;
    end
  end

endmodule

// File: rtl/instr_packer.sv
// Packs decoded RV64 instruction fields into 32-bit words tagged with a word address.
// Define INSTR_PACKER_RANGE_CHECK_EN to flag immediates that do not fit in 12 signed bits.
module instr_packer
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = 64'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [FUNCT3_W-1:0] in_funct3,
  input  logic [FUNCT7_W-1:0] in_funct7,
  input  logic [XLEN-1:0]     in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ILEN-1:0]     out_instr,
  output logic [XLEN-1:0]     out_addr,
  output logic                out_err
);

  fmt_e            fmt;
  logic [ILEN-1:0] instr_raw;
  logic            fmt_err, range_err;
  entry_t          push_entry, head, last_q, shown;
  logic [XLEN-1:0] addr_q;
  logic            full, empty, push, pop;
  logic [ENTRY_W-1:0] fifo_rdata;

  always_comb begin
    fmt       = decode_fmt(in_opcode);
    instr_raw = '0;
    fmt_err   = 1'b0;
    case (fmt)
      FmtI:  instr_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FmtS:  instr_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      // Branch immediate is already a halfword offset, so bit 0 of the field is imm[0].
      FmtSb: instr_raw = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3, in_imm[3:0],
                          in_imm[10], in_opcode};
      FmtR:  instr_raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default: fmt_err = 1'b1;
    endcase
  end

`ifdef INSTR_PACKER_RANGE_CHECK_EN
  assign range_err = (fmt inside {FmtI, FmtS, FmtSb}) &&
                     (in_imm[63:11] != {53{in_imm[11]}});
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[63:12];
  assign range_err     = 1'b0;
`endif

  always_comb begin
    push_entry.err   = fmt_err | range_err;
    push_entry.instr = push_entry.err ? '0 : instr_raw;
    push_entry.addr  = addr_q;
  end

  // in_ready depends only on local state, never on out_ready.
  assign in_ready  = ~full & ~reset;
  assign push      = in_valid & in_ready;
  assign out_valid = ~empty & ~reset;
  assign pop       = out_valid & out_ready;

  instr_fifo2 #(
    .Width(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(push_entry),
    .rdata(fifo_rdata),
    .full (full),
    .empty(empty)
  );

  assign head = entry_t'(fifo_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= BASE_ADDR;
      last_q <= '{instr: '0, addr: BASE_ADDR, err: 1'b0};
    end else begin
      if (push && !push_entry.err) addr_q <= addr_q + 64'd4;
      if (pop) last_q <= head;
    end
  end

  // Empty FIFO replays the last popped entry so the data outputs hold their value.
  always_comb begin
    if (reset)      shown = '{instr: '0, addr: BASE_ADDR, err: 1'b0};
    else if (empty) shown = last_q;
    else            shown = head;
  end

  assign out_instr = shown.instr;
  assign out_addr  = shown.addr;
  assign out_err   = shown.err;

endmodule
